sort_buffer_ctrl: RTL and testbench
===================================

Name: sort_buffer_ctrl

Overview:
- Sequential front end that captures a burst of 8-bit keys, sorts them in place, then streams them out in order.
- Drives the per-pair compare-and-select datapath: every compare-exchange decision becomes a select between two 8-bit operands.
- Sits between the upstream key source (valid/ready stream) and the downstream consumer (valid/ready stream).
- Load, sort and drain phases never overlap.

Parameters:
- WIDTH, 8, key width in bits.
- DEPTH, 8, buffer entries. Must be even and >= 2.
- DESCEND, 0. 0 gives ascending output order; 1 gives descending.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream key valid.
- in_ready  out  1  block accepts a key. High only in LOAD.
- in_data  in  WIDTH  upstream key.
- in_last  in  1  final key of burst. Sampled on the handshake only.
- out_valid  out  1  sorted key valid.
- out_ready  in  1  downstream accepts the key.
- out_data  out  WIDTH  sorted key.
- out_last  out  1  final sorted key of the burst.
- busy  out  1  high in SORT and DRAIN.

Behaviour:
- Reset (async assert, sync release):
  - state=LOAD; count=0; pass=0; rd_idx=0.
  - All buffer entries = pad value: all-ones when ascending, all-zeros when descending.
  - in_ready=0; out_valid=0; out_data=0; out_last=0; busy=0.
  - in_ready rises on the first clk edge after release.
- All outputs are registered. The handshake completes on a clk edge where valid && ready.
- LOAD:
  - Each handshake writes in_data to mem[count] and increments count.
  - Go to SORT if in_last=1 or count reaches DEPTH; in_ready drops the next cycle.
  - A DEPTH-th key with in_last=1 is a single transition.
  - A key arriving while in_ready=0 is not accepted and must be held by upstream.
  - count is never 0 on exit.
- SORT (odd-even transposition):
  - Exactly DEPTH cycles; pass counts 0..DEPTH-1.
  - Even pass compares pairs (0,1),(2,3)…; odd pass compares (1,2),(3,4)… Entry 0 and entry DEPTH-1 are untouched on odd passes.
  - Swap rule, ascending: swap when mem[i] > mem[i+1] (unsigned). Descending uses <. Equal keys are never swapped.
  - Pad entries sort to the tail and are never emitted.
  - Entry to DRAIN: out_valid=1 on the cycle after pass DEPTH-1 completes.
  - Total latency from the last input handshake to the first out_valid is DEPTH+1 cycles.
- DRAIN:
  - out_data=mem[rd_idx]; out_last=(rd_idx==count-1).
  - Each output handshake increments rd_idx.
  - out_valid/out_data hold stable while out_ready=0 (backpressure of any length).
  - After the handshake with out_last=1:
    - Next cycle: out_valid=0, busy=0, in_ready=1.
    - Buffer reset to pad value; count=0, rd_idx=0.
    - state=LOAD.
- Reset asserted mid-LOAD/SORT/DRAIN: partial burst discarded immediately; no output key is emitted afterwards.

Decomposition:
- Package sorter_pkg:
  - state enum {LOAD, SORT, DRAIN}.
  - Default WIDTH/DEPTH localparams.
  - Pad-value function of DESCEND.
- One sub-module, cmp_swap: purely combinational.
  - Inputs: two WIDTH keys and DESCEND.
  - Outputs: lo/hi keys plus the swap select bit.
  - Instantiated DEPTH/2 times; pair mapping is muxed by pass parity.
- The parent module holds the buffer, counters and FSM.

Test Plan:
- Full burst: load 8 keys 0x35,0x02,0xF0,0x7A,0x02,0x99,0x10,0x01 with out_ready=1 → output 0x01,0x02,0x02,0x10,0x35,0x7A,0x99,0xF0; out_last on 0xF0; first out_valid exactly 9 cycles after the last input handshake.
- Short burst: keys 0x40,0x05,0x22 with in_last on 0x22 → output 0x05,0x22,0x40 only; out_last on 0x40; no pad emitted.
- DESCEND=1, keys 0x00,0xFF,0x80,0x7F (DEPTH=4) → output 0xFF,0x80,0x7F,0x00.
- Backpressure: hold out_ready=0 for 5 cycles mid-drain → out_data stable and in_ready=0 throughout; the sequence resumes with no key lost or duplicated.
- Back-to-back bursts: a second burst presented during drain is stalled (in_ready=0), then accepted the cycle after the first burst's out_last handshake; the second result is sorted independently.
- Reset mid-SORT: assert rst_n=0 for 2 cycles → out_valid=0, busy=0, in_ready=1 one cycle after release; the next 2-key burst 0x09,0x03 → output 0x03,0x09.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared types and defaults for the sort buffer: FSM states, default geometry
// and the pad key that keeps unused entries at the tail after sorting.
package sorter_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Ascending pads with all-ones, descending with all-zeros.
  function automatic logic pad_bit(input logic descend);
    return !descend;
  endfunction

endpackage

// File: rtl/cmp_swap.sv
// One compare-exchange cell: orders a pair of keys and reports whether the
// pair had to be exchanged. Equal keys are never exchanged.
module cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             descend_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             swap_o
);

  assign swap_o = descend_i ? (a_i < b_i) : (a_i > b_i);
  assign lo_o   = swap_o ? b_i : a_i;
  assign hi_o   = swap_o ? a_i : b_i;

endmodule

// File: rtl/sort_buffer_ctrl.sv
// Burst sort buffer: loads up to DEPTH keys, runs DEPTH passes of odd-even
// transposition sort in place, then streams the loaded keys out in order.
//
//   state | meaning
//   LOAD  | accepting keys into mem[count]
//   SORT  | one compare-exchange pass per cycle, DEPTH passes
//   DRAIN | presenting mem[rd_idx] downstream until the last loaded key
module sort_buffer_ctrl
  import sorter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int NP = DEPTH / 2;
  localparam logic [WIDTH-1:0] PAD       = {WIDTH{pad_bit(DESCEND)}};
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [IW-1:0]    LAST_PASS = IW'(DEPTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [IW-1:0]    pass_q;
  logic [IW-1:0]    rd_idx_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_last_q;
  logic             busy_q;

  logic             odd_pass;
  logic [WIDTH-1:0] cmp_a  [NP];
  logic [WIDTH-1:0] cmp_b  [NP];
  logic [WIDTH-1:0] cmp_lo [NP];
  logic [WIDTH-1:0] cmp_hi [NP];
  logic             cmp_sel [NP];
  logic [WIDTH-1:0] mem_d  [DEPTH];

  assign odd_pass = pass_q[0];

  // Odd passes shift every comparator up by one entry; the top one idles.
  for (genvar k = 0; k < NP; k++) begin : g_pair
    if (k < NP - 1) begin : g_mid
      assign cmp_a[k] = odd_pass ? mem_q[2*k+1] : mem_q[2*k];
      assign cmp_b[k] = odd_pass ? mem_q[2*k+2] : mem_q[2*k+1];
    end else begin : g_top
      assign cmp_a[k] = mem_q[2*k];
      assign cmp_b[k] = mem_q[2*k+1];
    end

    cmp_swap #(.WIDTH(WIDTH)) u_cmp (
      .a_i      (cmp_a[k]),
      .b_i      (cmp_b[k]),
      .descend_i(DESCEND),
      .lo_o     (cmp_lo[k]),
      .hi_o     (cmp_hi[k]),
      .swap_o   (cmp_sel[k])
    );
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] even_v;
    logic [WIDTH-1:0] odd_v;

    if (i % 2 == 0) begin : g_even_lo
      assign even_v = cmp_sel[i/2] ? cmp_lo[i/2] : mem_q[i];
    end else begin : g_even_hi
      assign even_v = cmp_sel[i/2] ? cmp_hi[i/2] : mem_q[i];
    end

    if (i == 0 || i == DEPTH - 1) begin : g_odd_edge
      assign odd_v = mem_q[i];
    end else if (i % 2 == 1) begin : g_odd_lo
      assign odd_v = cmp_sel[(i-1)/2] ? cmp_lo[(i-1)/2] : mem_q[i];
    end else begin : g_odd_hi
      assign odd_v = cmp_sel[i/2-1] ? cmp_hi[i/2-1] : mem_q[i];
    end

    assign mem_d[i] = odd_pass ? odd_v : even_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      pass_q      <= '0;
      rd_idx_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PAD;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            mem_q[count_q[IW-1:0]] <= in_data;
            count_q <= count_q + CW'(1);
            if (in_last || count_q == DEPTH_C - CW'(1)) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              pass_q     <= '0;
            end
          end
        end

        SORT: begin
          for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
          pass_q <= pass_q + IW'(1);
          if (pass_q == LAST_PASS) begin
            state_q <= DRAIN;
            pass_q  <= '0;
          end
        end

        DRAIN: begin
          // First DRAIN cycle only presents mem[0]; afterwards each handshake advances.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_idx_q];
            out_last_q  <= (CW'(rd_idx_q) == count_q - CW'(1));
          end else if (out_ready) begin
            if (out_last_q) begin
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              count_q     <= '0;
              rd_idx_q    <= '0;
              for (int i = 0; i < DEPTH; i++) mem_q[i] <= PAD;
            end else begin
              rd_idx_q   <= rd_idx_q + IW'(1);
              out_data_q <= mem_q[rd_idx_q + IW'(1)];
              out_last_q <= (CW'(rd_idx_q) + CW'(2) == count_q);
            end
          end
        end

        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sort_buffer_ctrl.sv
// Directed bench for sort_buffer_ctrl: an ascending DEPTH=8 instance and a
// descending DEPTH=4 instance share clock and reset.
module tb_sort_buffer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, out_valid, out_last, busy;
  logic [7:0] out_data;

  logic       in_valid_d = 1'b0, in_last_d = 1'b0, out_ready_d = 1'b0;
  logic [7:0] in_data_d = 8'h00;
  logic       in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0] out_data_d;

  sort_buffer_ctrl #(.WIDTH(8), .DEPTH(8), .DESCEND(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  sort_buffer_ctrl #(.WIDTH(8), .DEPTH(4), .DESCEND(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_d), .in_ready(in_ready_d), .in_data(in_data_d), .in_last(in_last_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_data(out_data_d), .out_last(out_last_d),
    .busy(busy_d)
  );

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int first_hs_cyc = 0;
  int last_hs_cyc = 0;
  int last_out_hs_cyc = 0;

  logic [7:0] stim [8];
  logic [7:0] exp_q [8];
  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [7:0] got_d [$];
  logic       got_last_d [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output handshakes complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_last.push_back(out_last);
      if (out_last) last_out_hs_cyc = cyc + 1;
    end
    if (rst_n && out_valid_d && out_ready_d) begin
      got_d.push_back(out_data_d);
      got_last_d.push_back(out_last_d);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_keys(input int n, input bit last_on_end);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = last_on_end && (i == n - 1);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!ok) begin
        tests++; failed++;
        $display("FAIL send_timeout: key %0d never accepted", i);
      end
      if (i == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_outputs(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (got_data.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin failed++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    tests++; if (out_last !== 1'b0) begin failed++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL release_in_ready_early: got %0b want 0", in_ready); end
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    tests++; if (in_ready_d !== 1'b1) begin failed++; $display("FAIL release_in_ready_d: got %0b want 1", in_ready_d); end
  endtask

  task automatic test_descend();
    logic [7:0] keys [4];
    logic [7:0] want [4];
    bit ok;
    keys = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    want = '{8'hFF, 8'h80, 8'h7F, 8'h00};
    got_d.delete(); got_last_d.delete();
    out_ready_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid_d = 1'b1; in_data_d = keys[i]; in_last_d = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (in_ready_d) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!ok) begin tests++; failed++; $display("FAIL desc_send_timeout: key %0d", i); end
    end
    in_valid_d = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk); #1;
      if (got_d.size() >= 4) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin failed++; $display("FAIL desc_count: got %0d keys want 4", got_d.size()); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_d[i] !== want[i]) begin failed++; $display("FAIL desc_data[%0d]: got %h want %h", i, got_d[i], want[i]); end
      tests++;
      if (got_last_d[i] !== (i == 3)) begin failed++; $display("FAIL desc_last[%0d]: got %0b want %0b", i, got_last_d[i], (i == 3)); end
    end
    repeat (2) @(posedge clk); #1;
    tests++; if (busy_d !== 1'b0 || in_ready_d !== 1'b1) begin failed++; $display("FAIL desc_idle: busy %0b in_ready %0b want 0/1", busy_d, in_ready_d); end
    out_ready_d = 1'b0;
  endtask

  task automatic test_full_burst();
    bit ok;
    stim  = '{8'h35, 8'h02, 8'hF0, 8'h7A, 8'h02, 8'h99, 8'h10, 8'h01};
    exp_q = '{8'h01, 8'h02, 8'h02, 8'h10, 8'h35, 8'h7A, 8'h99, 8'hF0};
    got_data.delete(); got_last.delete();
    out_ready = 1'b1;
    send_keys(8, 1'b0);
    #1;
    tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL full_enter_sort: in_ready %0b busy %0b want 0/1", in_ready, busy); end
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    tests++;
    if (!ok || (cyc - last_hs_cyc) != 9) begin failed++; $display("FAIL full_latency: got %0d cycles want 9", cyc - last_hs_cyc); end
    wait_outputs(8, ok);
    tests++; if (!ok) begin failed++; $display("FAIL full_count: got %0d keys want 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_data[i] !== exp_q[i]) begin failed++; $display("FAIL full_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
      tests++;
      if (got_last[i] !== (i == 7)) begin failed++; $display("FAIL full_last[%0d]: got %0b want %0b", i, got_last[i], (i == 7)); end
    end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL full_exit: out_valid %0b busy %0b in_ready %0b want 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_short_burst();
    bit ok;
    stim  = '{8'h40, 8'h05, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_q = '{8'h05, 8'h22, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    got_data.delete(); got_last.delete();
    out_ready = 1'b1;
    send_keys(3, 1'b1);
    wait_outputs(3, ok);
    tests++; if (!ok) begin failed++; $display("FAIL short_count: got %0d keys want 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got_data[i] !== exp_q[i]) begin failed++; $display("FAIL short_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
      tests++;
      if (got_last[i] !== (i == 2)) begin failed++; $display("FAIL short_last[%0d]: got %0b want %0b", i, got_last[i], (i == 2)); end
    end
    repeat (12) @(posedge clk); #1;
    tests++; if (got_data.size() != 3) begin failed++; $display("FAIL short_no_pad: got %0d keys want 3", got_data.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    stim  = '{8'h80, 8'h11, 8'hEE, 8'h11, 8'h00, 8'h55, 8'hA0, 8'h3C};
    exp_q = '{8'h00, 8'h11, 8'h11, 8'h3C, 8'h55, 8'h80, 8'hA0, 8'hEE};
    got_data.delete(); got_last.delete();
    out_ready = 1'b0;
    send_keys(8, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin failed++; $display("FAIL bp_first_valid: out_valid never rose"); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0) begin
        failed++;
        $display("FAIL bp_hold[%0d]: valid %0b data %h in_ready %0b want 1/3c/0", c, out_valid, out_data, in_ready);
      end
    end
    tests++; if (got_data.size() != 3) begin failed++; $display("FAIL bp_stalled_count: got %0d keys want 3", got_data.size()); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_outputs(8, ok);
    tests++; if (!ok) begin failed++; $display("FAIL bp_count: got %0d keys want 8", got_data.size()); end
    repeat (3) @(posedge clk); #1;
    tests++; if (got_data.size() != 8) begin failed++; $display("FAIL bp_no_dup: got %0d keys want 8", got_data.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_data[i] !== exp_q[i]) begin failed++; $display("FAIL bp_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
    end
    tests++; if (got_last[7] !== 1'b1) begin failed++; $display("FAIL bp_last: got %0b want 1", got_last[7]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] want [7];
    want = '{8'h0A, 8'h0B, 8'h0C, 8'h0F, 8'h31, 8'h32, 8'h33};
    got_data.delete(); got_last.delete();
    out_ready = 1'b1;
    stim = '{8'h0F, 8'h0A, 8'h0C, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};
    send_keys(4, 1'b1);
    stim = '{8'h33, 8'h31, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_keys(3, 1'b1);
    tests++;
    if (first_hs_cyc != last_out_hs_cyc + 1) begin
      failed++; $display("FAIL b2b_accept_cycle: got %0d want %0d", first_hs_cyc, last_out_hs_cyc + 1);
    end
    tests++; if (got_data.size() != 4) begin failed++; $display("FAIL b2b_first_done: got %0d keys want 4", got_data.size()); end
    wait_outputs(7, ok);
    tests++; if (!ok) begin failed++; $display("FAIL b2b_count: got %0d keys want 7", got_data.size()); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (got_data[i] !== want[i]) begin failed++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], want[i]); end
      tests++;
      if (got_last[i] !== (i == 3 || i == 6)) begin failed++; $display("FAIL b2b_last[%0d]: got %0b want %0b", i, got_last[i], (i == 3 || i == 6)); end
    end
  endtask

  task automatic test_reset_mid_sort();
    bit ok;
    got_data.delete(); got_last.delete();
    out_ready = 1'b1;
    stim = '{8'h50, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_keys(2, 1'b1);
    @(posedge clk); #1;
    tests++; if (busy !== 1'b1) begin failed++; $display("FAIL rst_mid_in_sort: busy %0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin failed++; $display("FAIL rst_mid_async: busy %0b in_ready %0b want 0/0", busy, in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failed++; $display("FAIL rst_mid_release: out_valid %0b busy %0b in_ready %0b want 0/0/1", out_valid, busy, in_ready);
    end
    repeat (15) @(posedge clk); #1;
    tests++; if (got_data.size() != 0) begin failed++; $display("FAIL rst_mid_discard: got %0d keys want 0", got_data.size()); end
    stim = '{8'h09, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_keys(2, 1'b1);
    wait_outputs(2, ok);
    tests++; if (!ok) begin failed++; $display("FAIL rst_mid_count: got %0d keys want 2", got_data.size()); end
    tests++; if (got_data[0] !== 8'h03) begin failed++; $display("FAIL rst_mid_data0: got %h want 03", got_data[0]); end
    tests++; if (got_data[1] !== 8'h09) begin failed++; $display("FAIL rst_mid_data1: got %h want 09", got_data[1]); end
    tests++; if (got_last[1] !== 1'b1 || got_last[0] !== 1'b0) begin
      failed++; $display("FAIL rst_mid_last: got %0b%0b want 01", got_last[0], got_last[1]);
    end
  endtask

  initial begin
    test_reset();
    test_descend();
    test_full_burst();
    test_short_burst();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sort();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
